// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline registers.
// Holds control-bundle layout, register field positions and reset defaults.
package pipe_pkg;

    localparam int          DEF_ALUOP_W   = 6;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8002_0000;

    localparam int REG_W  = 5;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

    typedef struct packed {
        logic                   br;
        logic                   jp;
        logic                   aluinb;
        logic [DEF_ALUOP_W-1:0] aluop;
        logic                   dmwe;
        logic                   rwe;
        logic                   rdst;
        logic                   rwd;
    } dx_ctrl_t;

    function automatic dx_ctrl_t bubble_ctrl();
        dx_ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use hazard detector between the X and D slots.
// Only elaborated when DX_LOADUSE_HAZARD_EN is defined.
`ifdef DX_LOADUSE_HAZARD_EN
module hazard_unit
    import pipe_pkg::*;
(
    input  logic             x_valid,
    input  logic             x_rwe,
    input  logic             x_rwd,
    input  logic             x_rdst,
    input  logic [REG_W-1:0] x_rt,
    input  logic [REG_W-1:0] x_rd,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    output logic             hz
);

    logic [REG_W-1:0] x_dst;

    // A load in X whose destination is read by D must be separated by one bubble.
    always_comb begin
        x_dst = x_rdst ? x_rd : x_rt;
        hz    = x_valid && x_rwe && x_rwd && (x_dst != '0) && d_valid &&
                ((x_dst == d_rs) || (x_dst == d_rt));
    end

endmodule
`endif

// File: rtl/dx_pipe_stage.sv
// Decode-to-execute pipeline register with stall, flush and load-use bubbles.
// Hazard detection and its bubble counter exist only with DX_LOADUSE_HAZARD_EN.
module dx_pipe_stage
    import pipe_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int                DATA_W    = 32,
    parameter int                ALUOP_W   = DEF_ALUOP_W,
    parameter int                CNT_W     = 16
)(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall_in,
    input  logic               flush_in,
    input  logic               d_valid,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [31:0]        d_insn,
    input  logic [DATA_W-1:0]  d_ra,
    input  logic [DATA_W-1:0]  d_rb,
    input  logic               d_br,
    input  logic               d_jp,
    input  logic               d_aluinb,
    input  logic [ALUOP_W-1:0] d_aluop,
    input  logic               d_dmwe,
    input  logic               d_rwe,
    input  logic               d_rdst,
    input  logic               d_rwd,
    output logic               x_valid,
    output logic [ADDR_W-1:0]  x_pc,
    output logic [31:0]        x_insn,
    output logic [DATA_W-1:0]  x_ra,
    output logic [DATA_W-1:0]  x_rb,
    output logic               x_br,
    output logic               x_jp,
    output logic               x_aluinb,
    output logic [ALUOP_W-1:0] x_aluop,
    output logic               x_dmwe,
    output logic               x_rwe,
    output logic               x_rdst,
    output logic               x_rwd,
    output logic               fd_stall,
    output logic [CNT_W-1:0]   hazard_cnt
);

    dx_ctrl_t d_ctrl;
    dx_ctrl_t x_ctrl_q;
    logic     hz;
    logic     take_bubble;

    assign d_ctrl = '{br: d_br, jp: d_jp, aluinb: d_aluinb, aluop: d_aluop,
                      dmwe: d_dmwe, rwe: d_rwe, rdst: d_rdst, rwd: d_rwd};

`ifdef DX_LOADUSE_HAZARD_EN
    hazard_unit u_hazard_unit (
        .x_valid (x_valid),
        .x_rwe   (x_ctrl_q.rwe),
        .x_rwd   (x_ctrl_q.rwd),
        .x_rdst  (x_ctrl_q.rdst),
        .x_rt    (x_insn[RT_LSB +: REG_W]),
        .x_rd    (x_insn[RD_LSB +: REG_W]),
        .d_valid (d_valid),
        .d_rs    (d_insn[RS_LSB +: REG_W]),
        .d_rt    (d_insn[RT_LSB +: REG_W]),
        .hz      (hz)
    );

    logic [CNT_W-1:0] hazard_cnt_q;

    // Only bubbles that actually came from a hazard count; flush or stall suppress it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hazard_cnt_q <= '0;
        end else if (!flush_in && !stall_in && hz && (hazard_cnt_q != '1)) begin
            hazard_cnt_q <= hazard_cnt_q + 1'b1;
        end
    end

    assign hazard_cnt = hazard_cnt_q;
`else
    assign hz         = 1'b0;
    assign hazard_cnt = '0;
`endif

    assign take_bubble = flush_in || (!stall_in && hz);
    assign fd_stall    = stall_in || (hz && !flush_in);

    // A bubble keeps the PC so the slot still reports where it sits in the stream.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_valid  <= 1'b0;
            x_pc     <= BASE_ADDR;
            x_insn   <= '0;
            x_ra     <= '0;
            x_rb     <= '0;
            x_ctrl_q <= bubble_ctrl();
        end else if (take_bubble) begin
            x_valid  <= 1'b0;
            x_insn   <= '0;
            x_ra     <= '0;
            x_rb     <= '0;
            x_ctrl_q <= bubble_ctrl();
        end else if (!stall_in) begin
            x_valid  <= d_valid;
            x_pc     <= d_pc;
            x_insn   <= d_insn;
            x_ra     <= d_ra;
            x_rb     <= d_rb;
            x_ctrl_q <= d_ctrl;
        end
    end

    assign x_br     = x_ctrl_q.br;
    assign x_jp     = x_ctrl_q.jp;
    assign x_aluinb = x_ctrl_q.aluinb;
    assign x_aluop  = x_ctrl_q.aluop;
    assign x_dmwe   = x_ctrl_q.dmwe;
    assign x_rwe    = x_ctrl_q.rwe;
    assign x_rdst   = x_ctrl_q.rdst;
    assign x_rwd    = x_ctrl_q.rwd;

endmodule

// File: tb/tb_dx_pipe_stage.sv
// Scoreboard bench for dx_pipe_stage; expectations follow DX_LOADUSE_HAZARD_EN.
// Counter width is shrunk to 2 bits so saturation is reachable quickly.
module tb_dx_pipe_stage;

    localparam int CNT_W = 2;
`ifdef DX_LOADUSE_HAZARD_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif

    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_ADDI = 7'b0000100;
    localparam logic [6:0] F_LW   = 7'b0010101;
    localparam logic [6:0] F_ADD  = 7'b0000110;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             stall_in = 1'b0, flush_in = 1'b0, d_valid = 1'b0;
    logic [31:0]      d_pc = '0, d_insn = '0, d_ra = '0, d_rb = '0;
    logic             d_br = 1'b0, d_jp = 1'b0, d_aluinb = 1'b0, d_dmwe = 1'b0;
    logic             d_rwe = 1'b0, d_rdst = 1'b0, d_rwd = 1'b0;
    logic [5:0]       d_aluop = '0;
    logic             x_valid, x_br, x_jp, x_aluinb, x_dmwe, x_rwe, x_rdst, x_rwd;
    logic [31:0]      x_pc, x_insn, x_ra, x_rb;
    logic [5:0]       x_aluop;
    logic             fd_stall;
    logic [CNT_W-1:0] hazard_cnt;

    dx_pipe_stage #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
        .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn), .d_ra(d_ra), .d_rb(d_rb),
        .d_br(d_br), .d_jp(d_jp), .d_aluinb(d_aluinb), .d_aluop(d_aluop),
        .d_dmwe(d_dmwe), .d_rwe(d_rwe), .d_rdst(d_rdst), .d_rwd(d_rwd),
        .x_valid(x_valid), .x_pc(x_pc), .x_insn(x_insn), .x_ra(x_ra), .x_rb(x_rb),
        .x_br(x_br), .x_jp(x_jp), .x_aluinb(x_aluinb), .x_aluop(x_aluop),
        .x_dmwe(x_dmwe), .x_rwe(x_rwe), .x_rdst(x_rdst), .x_rwd(x_rwd),
        .fd_stall(fd_stall), .hazard_cnt(hazard_cnt)
    );

    always #5 clock = ~clock;

    // Flags ordered {br, jp, aluinb, dmwe, rwe, rdst, rwd}.
    typedef struct packed {
        logic             valid;
        logic [31:0]      pc, insn, ra, rb;
        logic [5:0]       aluop;
        logic [6:0]       flags;
        logic [CNT_W-1:0] cnt;
    } xstate_t;

    xstate_t m;
    xstate_t q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic xstate_t reset_state();
        xstate_t s;
        s    = '0;
        s.pc = 32'h8002_0000;
        return s;
    endfunction

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input xstate_t e);
        compare({tag, ".x_valid"}, 64'(x_valid), 64'(e.valid));
        compare({tag, ".x_pc"}, 64'(x_pc), 64'(e.pc));
        compare({tag, ".x_insn"}, 64'(x_insn), 64'(e.insn));
        compare({tag, ".x_ra_rb"}, {x_ra, x_rb}, {e.ra, e.rb});
        compare({tag, ".x_aluop"}, 64'(x_aluop), 64'(e.aluop));
        compare({tag, ".x_flags"}, 64'({x_br, x_jp, x_aluinb, x_dmwe, x_rwe, x_rdst, x_rwd}), 64'(e.flags));
        compare({tag, ".hazard_cnt"}, 64'(hazard_cnt), 64'(e.cnt));
    endtask

    task automatic checkOutput(input string tag);
        xstate_t e;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            checkState(tag, e);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [31:0] pc,
                                 input logic [31:0] insn, input logic [5:0] aluop,
                                 input logic [6:0] fl, input logic st, input logic fls);
        logic [4:0] dst;
        logic       hz;
        d_valid = v; d_pc = pc; d_insn = insn; d_aluop = aluop;
        d_ra = $urandom; d_rb = $urandom;
        {d_br, d_jp, d_aluinb, d_dmwe, d_rwe, d_rdst, d_rwd} = fl;
        stall_in = st; flush_in = fls;
        #1;
        dst = m.flags[1] ? m.insn[15:11] : m.insn[20:16];
        hz  = HZ_EN && m.valid && m.flags[2] && m.flags[0] && (dst != 5'd0) && v &&
              ((dst == insn[25:21]) || (dst == insn[20:16]));
        compare({tag, ".fd_stall"}, 64'(fd_stall), 64'(st | (hz & ~fls)));
        if (fls || (!st && hz)) begin
            if (!fls && m.cnt != '1) m.cnt = m.cnt + 1'b1;
            m = '{valid: 1'b0, pc: m.pc, insn: '0, ra: '0, rb: '0, aluop: '0, flags: '0, cnt: m.cnt};
        end else if (!st) begin
            m = '{valid: v, pc: pc, insn: insn, ra: d_ra, rb: d_rb, aluop: aluop, flags: fl, cnt: m.cnt};
        end
        q.push_back(m);
        @(posedge clock);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        m = reset_state();
        stall_in = 1'b1;
        @(posedge clock);
        #1;
        checkState("reset", reset_state());
        compare("reset.fd_stall_hi", 64'(fd_stall), 64'd1);
        stall_in = 1'b0;
        #1;
        compare("reset.fd_stall_lo", 64'(fd_stall), 64'd0);

        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus("addi", 1'b1, 32'h8002_0000, 32'h2001_0005, 6'h08, F_ADDI, 1'b0, 1'b0);
        applyStimulus("lw", 1'b1, 32'h8002_0004, 32'h8C22_0000, 6'h08, F_LW, 1'b0, 1'b0);
        applyStimulus("add_hz", 1'b1, 32'h8002_0008, 32'h0042_1820, 6'h20, F_ADD, 1'b0, 1'b0);
        applyStimulus("add_go", 1'b1, 32'h8002_0008, 32'h0042_1820, 6'h20, F_ADD, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++)
            applyStimulus("stall", 1'b1, 32'h8002_0010 + 32'(4 * i), 32'h0062_2022 + 32'(i), 6'h22, F_ADD, 1'b1, 1'b0);
        applyStimulus("resume", 1'b1, 32'h8002_000C, 32'h0062_2022, 6'h22, F_ADD, 1'b0, 1'b0);

        applyStimulus("lw4", 1'b1, 32'h8002_0010, 32'h8C24_0000, 6'h08, F_LW, 1'b0, 1'b0);
        applyStimulus("flush_all", 1'b1, 32'h8002_0014, 32'h0084_2820, 6'h20, F_ADD, 1'b1, 1'b1);
        applyStimulus("after_flush", 1'b1, 32'h8002_0014, 32'h0084_2820, 6'h20, F_ADD, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus("sat_lw", 1'b1, 32'h8002_0100, 32'h8C22_0000, 6'h08, F_LW, 1'b0, 1'b0);
            applyStimulus("sat_hz", 1'b1, 32'h8002_0104, 32'h0042_1820, 6'h20, F_ADD, 1'b0, 1'b0);
            applyStimulus("sat_add", 1'b1, 32'h8002_0104, 32'h0042_1820, 6'h20, F_ADD, 1'b0, 1'b0);
        end
        applyStimulus("invalid_d", 1'b0, 32'h8002_0108, 32'h0000_0000, 6'h00, F_NONE, 1'b0, 1'b0);

        applyStimulus("pre_rst", 1'b1, 32'h8002_0200, 32'h8C22_0000, 6'h08, F_LW, 1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        checkState("async_rst", reset_state());
        @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        m = reset_state();
        applyStimulus("post_rst", 1'b1, 32'h8002_0000, 32'h2001_0005, 6'h08, F_ADDI, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dx_pipe_stage.md
# dx_pipe_stage

Parametrised decode-to-execute (D/X) pipeline register for the MIPS pipeline, sitting between `decode` and the execute stage. It latches PC, instruction, register operands and decode control bits each cycle, adding a valid bit, external stall (hold), flush (bubble) and load-use hazard detection. It also drives a stall request back to `fetch` and the F/D latch, and keeps a saturating count of inserted hazard bubbles.

## Interface
- `BASE_ADDR`, 32'h80020000: reset value of `x_pc`.
- `ADDR_W`, 32: PC width.
- `DATA_W`, 32: register operand width.
- `ALUOP_W`, 6: ALU opcode width.
- `CNT_W`, 16: hazard bubble counter width.

- `clock`  in  1  single clock for the block; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  freeze request from memory busy; hold all DX state.
- `flush_in`  in  1  taken branch/jump in X; next DX contents become a bubble.
- `d_valid`  in  1  decode slot holds a real instruction.
- `d_pc`  in  ADDR_W  decode PC.
- `d_insn`  in  32  decode instruction word.
- `d_ra`, `d_rb`  in  DATA_W  register file read data.
- `d_br`, `d_jp`, `d_aluinb`, `d_dmwe`, `d_rwe`, `d_rdst`, `d_rwd`  in  1 each  decode control bits.
- `d_aluop`  in  ALUOP_W  ALU opcode.
- `x_valid`, `x_pc`, `x_insn`, `x_ra`, `x_rb`, `x_br`, `x_jp`, `x_aluinb`, `x_aluop`, `x_dmwe`, `x_rwe`, `x_rdst`, `x_rwd`  out  (widths as inputs)  registered DX contents.
- `fd_stall`  out  1  hold PC and F/D latch this cycle.
- `hazard_cnt`  out  CNT_W  saturating count of load-use bubbles.

## Operation
- Next-state priority, high to low: reset, `flush_in`, `stall_in`, hazard, load.
- Reset (`reset_n`=0, asynchronous): `x_pc`=BASE_ADDR; every other `x_*` is 0; `hazard_cnt`=0. `fd_stall` then evaluates to `stall_in`.
- Flush: DX becomes a bubble. A bubble has `x_valid`=0 and every other `x_*` field 0, except `x_pc`, which holds its value. Flush wins over a simultaneous stall or hazard.
- Stall: all `x_*` hold their values and `hazard_cnt` holds.
- Hazard, named `hz`. The following signals feed it:
  - `x_dst` = `x_rdst` ? `x_insn[15:11]` : `x_insn[20:16]`.
  - `hz` = `x_valid` & `x_rwe` & `x_rwd` & (`x_dst`≠0) & `d_valid` & (`x_dst`==`d_insn[25:21]` | `x_dst`==`d_insn[20:16]`).
  - When `hz` is set: DX loads a bubble, and `hazard_cnt` increments, saturating at all-ones.
- Load: all `x_*` take the corresponding `d_*` values, and `x_valid`=`d_valid`.
- `fd_stall` = `stall_in` | (`hz` & ~`flush_in`). It is combinational.

## Timing
- One-cycle latency, D to X, for a load.
- A hazard stalls for exactly one cycle: the bubble in X clears `hz` on the next cycle, and the held instruction then loads.
- Back-to-back loads with dependents produce one bubble per dependent pair.
- `flush_in` and `hz` in the same cycle: the bubble is inserted and the counter does not increment.
- Reset asserted mid-stall: outputs clear immediately, with no clock needed.

## Configuration
- `DX_LOADUSE_HAZARD_EN`:
  - Defined: hazard detection, bubble insertion and `hazard_cnt` operate as above.
  - Undefined: `hz` is tied to 0, `fd_stall`=`stall_in`, and `hazard_cnt` is constant 0. Load-use hazards are left to the software scheduler.

## Structure
- Package `pipe_pkg` holds:
  - `ALUOP_W` default and the `BASE_ADDR` default.
  - Register field positions (RS_LSB=21, RT_LSB=16, RD_LSB=11).
  - Struct `dx_ctrl_t`, which bundles br/jp/aluinb/aluop/dmwe/rwe/rdst/rwd.
  - Function `bubble_ctrl()`, which returns all-zero control.
- Sub-module `hazard_unit` is combinational and computes `hz` from the X and D fields. It is instantiated only under `DX_LOADUSE_HAZARD_EN`.

## Test plan
- Reset, then drive `d_valid`=1, `d_pc`=80020000, `d_insn`=20010005 (addi), `d_aluop`=8 -> one cycle later `x_valid`=1, `x_pc`=80020000, `x_aluop`=8, `fd_stall`=0.
- Load `lw $2,0($1)` (8C220000) with `rwe`=`rwd`=1, then in D `add $3,$2,$2` (00421820) -> `fd_stall`=1 for one cycle, X holds a bubble, the add appears in X the following cycle, `hazard_cnt`=1.
- `stall_in`=1 for 3 cycles while D changes -> `x_*` unchanged and `fd_stall`=1 throughout; loading resumes on the first cycle after release.
- `flush_in`=1 together with `stall_in`=1 and a hazard -> X becomes a bubble (`x_valid`=0, `x_rwe`=0), `hazard_cnt` unchanged.
- Set `CNT_W`=2 and force 5 hazards -> `hazard_cnt` saturates at 3. Pulse `reset_n`=0 asynchronously mid-cycle -> all outputs clear at once and `x_pc`=80020000.
- Build without `DX_LOADUSE_HAZARD_EN` and repeat the lw/add pair -> no bubble, the add follows the lw directly, `fd_stall`=0.
